// File: rtl/stage_sequencer_pkg.sv
// Shared stage constants and types for the stage sequencer.
// The stage count comes from the NUM_STAGES macro and defaults to 5.
`ifndef NUM_STAGES
`define NUM_STAGES 5
`endif

package stage_sequencer_pkg;

  localparam int NUM_STAGES = `NUM_STAGES;
  localparam int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [STAGE_W-1:0] STAGE_FETCH   = '0;
  localparam logic [STAGE_W-1:0] DEFAULT_STAGE = STAGE_FETCH;

  typedef logic [NUM_STAGES-1:0] stage_vec_t;

  // Stage enables are active-low, so the idle/reset vector has only the fetch bit low.
  localparam stage_vec_t STAGE_RESET_N = ~stage_vec_t'(1);

  typedef enum logic [1:0] {
    HALT_NONE  = 2'd0,
    HALT_FAULT = 2'd1,
    HALT_WDOG  = 2'd2
  } halt_cause_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_t;

  function automatic stage_vec_t stage_onehot(input logic [STAGE_W-1:0] idx);
    stage_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage datapath blocks and the stage sequencer.
// master drives done/skip/control requests; slave is the sequencer itself.
interface stage_sequencer_if #(
  parameter int CNT_W = 16
);
  import stage_sequencer_pkg::*;

  stage_vec_t         stage_done;
  stage_vec_t         skip_mask;
  logic               stall;
  logic               fault;
  logic               resume;
  stage_vec_t         stage_active_n;
  logic [STAGE_W-1:0] cur_stage;
  logic               retire;
  logic [CNT_W-1:0]   retire_count;
  logic               halted;
  halt_cause_t        halt_cause;

  modport master (
    output stage_done, skip_mask, stall, fault, resume,
    input  stage_active_n, cur_stage, retire, retire_count, halted, halt_cause
  );

  modport slave (
    input  stage_done, skip_mask, stall, fault, resume,
    output stage_active_n, cur_stage, retire, retire_count, halted, halt_cause
  );

endinterface

// File: rtl/stage_sequencer_dff.sv
// Generic register cell with asynchronous active-low clear to a parameterised value.
module dff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) q <= RESET_VAL;
    else          q <= d;
  end

endmodule

// File: rtl/stage_sequencer_stage_next_sel.sv
// Picks the next non-skipped stage after the current one, or flags a wrap back to fetch.
module stage_next_sel
  import stage_sequencer_pkg::*;
(
  input  logic [STAGE_W-1:0]    cur_stage,
  input  logic [NUM_STAGES-1:1] skip_upper,
  output logic [STAGE_W-1:0]    next_stage,
  output logic                  wrap
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    next_stage = STAGE_FETCH;
    wrap       = 1'b1;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if ((j > int'(cur_stage)) && !skip_upper[j]) begin
        next_stage = STAGE_W'(j);
        wrap       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: steps the active-low one-hot stage register, retires instructions, halts on fault.
// Optional STAGE_SEQ_WATCHDOG_EN adds a per-stage timeout that halts with cause HALT_WDOG.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef STAGE_SEQ_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 64
`endif
) (
  input logic               clk,
  input logic               clear_n,
  stage_sequencer_if.slave  bus
);

  seq_state_t         state;
  stage_vec_t         active_n;
  stage_vec_t         active_n_d;
  logic [STAGE_W-1:0] cur_stage;
  logic [STAGE_W-1:0] next_stage;
  logic               wrap;
  logic               advance;
  logic               wdog_expire;
  logic               halt_req;
  halt_cause_t        halt_cause;
  halt_cause_t        cause_d;
  logic               retire;
  logic [CNT_W-1:0]   retire_count;

  stage_next_sel u_next_sel (
    .cur_stage  (cur_stage),
    .skip_upper (bus.skip_mask[NUM_STAGES-1:1]),
    .next_stage (next_stage),
    .wrap       (wrap)
  );

  assign advance = (state == RUN) && bus.stage_done[cur_stage] && !bus.stall && !bus.fault;

`ifdef STAGE_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Stall cycles count too; any stage change or halt restarts the count.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                        wdog_cnt <= '0;
    else if ((state != RUN) || advance)  wdog_cnt <= '0;
    else                                 wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_expire = (state == RUN) && !advance && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  assign halt_req = (state == RUN) && (bus.fault || wdog_expire);
  assign cause_d  = bus.fault ? HALT_FAULT : HALT_WDOG;

  always_comb begin
    active_n_d = active_n;
    if (state == RUN) begin
      if (halt_req)     active_n_d = '1;
      else if (advance) active_n_d = ~stage_onehot(next_stage);
    end else if (bus.resume && !bus.fault) begin
      active_n_d = STAGE_RESET_N;
    end
  end

  dff #(
    .WIDTH     (NUM_STAGES),
    .RESET_VAL (STAGE_RESET_N)
  ) u_stage_reg (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (active_n_d),
    .q       (active_n)
  );

  // A fault on the final done edge halts instead of retiring.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state        <= RUN;
      cur_stage    <= DEFAULT_STAGE;
      retire       <= 1'b0;
      retire_count <= '0;
      halt_cause   <= HALT_NONE;
    end else begin
      retire <= 1'b0;
      case (state)
        RUN: begin
          if (halt_req) begin
            state      <= HALTED;
            halt_cause <= cause_d;
          end else if (advance) begin
            cur_stage <= next_stage;
            if (wrap) begin
              retire       <= 1'b1;
              retire_count <= retire_count + 1'b1;
            end
          end
        end
        HALTED: begin
          if (bus.resume && !bus.fault) begin
            state      <= RUN;
            cur_stage  <= DEFAULT_STAGE;
            halt_cause <= HALT_NONE;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.stage_active_n = active_n;
  assign bus.cur_stage      = cur_stage;
  assign bus.retire         = retire;
  assign bus.retire_count   = retire_count;
  assign bus.halted         = (state == HALTED);
  assign bus.halt_cause     = halt_cause;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (5 stages, 16-bit retire counter).
// Exercises STAGE_SEQ_WATCHDOG_EN behaviour when that macro is defined.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        clear_n;
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_count;

  stage_sequencer_if #(.CNT_W(16)) bus ();

  stage_sequencer #(.CNT_W(16)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input stage_vec_t done, input stage_vec_t skip,
                                input logic stall, input logic fault, input logic resume);
    bus.stage_done = done;
    bus.skip_mask  = skip;
    bus.stall      = stall;
    bus.fault      = fault;
    bus.resume     = resume;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input int stage, input logic ret);
    stage_vec_t exp_vec;
    exp_vec = ~(stage_vec_t'(1) << stage);
    check_output({tag, ".cur_stage"}, 32'(bus.cur_stage), 32'(stage));
    check_output({tag, ".active_n"}, 32'(bus.stage_active_n), 32'(exp_vec));
    check_output({tag, ".retire"}, 32'(bus.retire), 32'(ret));
    check_output({tag, ".count"}, 32'(bus.retire_count), 32'(exp_count));
    check_output({tag, ".halted"}, 32'(bus.halted), 32'd0);
  endtask

  task automatic check_halted(input string tag, input int stage, input int cause);
    check_output({tag, ".halted"}, 32'(bus.halted), 32'd1);
    check_output({tag, ".active_n"}, 32'(bus.stage_active_n), 32'h1f);
    check_output({tag, ".cause"}, 32'(bus.halt_cause), 32'(cause));
    check_output({tag, ".cur_stage"}, 32'(bus.cur_stage), 32'(stage));
    check_output({tag, ".retire"}, 32'(bus.retire), 32'd0);
    check_output({tag, ".count"}, 32'(bus.retire_count), 32'(exp_count));
  endtask

  int seq_skip[4] = '{1, 2, 4, 0};

  initial begin
    exp_count = '0;
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0);
    clear_n = 1'b0;
    #12;
    check_run("reset", 0, 1'b0);
    check_output("reset.cause", 32'(bus.halt_cause), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    step();

    // Full walk with every done bit high and nothing skipped.
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 5; s++) begin
      step();
      if (s == 5) exp_count++;
      check_run($sformatf("walk%0d", s), s % 5, s == 5);
    end

    apply_stimulus(5'b11111, 5'b01000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) exp_count++;
      check_run($sformatf("skip3_%0d", i), seq_skip[i], i == 3);
    end

    // Done on inactive stages only must not advance.
    apply_stimulus(5'b11110, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    check_run("inactive_done", 0, 1'b0);

    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_run("to_stage2", 2, 1'b0);
    apply_stimulus(5'b11111, 5'b00000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_run($sformatf("stall%0d", i), 2, 1'b0);
    end
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    check_run("unstall", 3, 1'b0);
    step();
    check_run("to_stage4", 4, 1'b0);

    // Fault beats the final done: halt without retiring.
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b1, 1'b0);
    step();
    check_halted("fault", 4, 1);
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    check_halted("halt_hold", 4, 1);
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b1, 1'b1);
    step();
    check_halted("fault_resume", 4, 1);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
    step();
    check_run("resume", 0, 1'b0);
    check_output("resume.cause", 32'(bus.halt_cause), 32'd0);

    // Reset in the middle of an instruction returns to fetch.
    apply_stimulus(5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_run("pre_reset", 2, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0);
    clear_n = 1'b0;
    #2;
    exp_count = '0;
    check_run("mid_reset", 0, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;
    step();

    // Every stage but fetch skipped: one retire per edge, then counter wrap.
    apply_stimulus(5'b11111, 5'b11110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) begin
      step();
      exp_count++;
    end
    check_run("count_max", 0, 1'b1);
    check_output("count_is_ffff", 32'(bus.retire_count), 32'h0000ffff);
    step();
    exp_count++;
    check_run("count_wrap", 0, 1'b1);
    check_output("count_is_0", 32'(bus.retire_count), 32'd0);

    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(5'b00001, 5'b00000, 1'b0, 1'b0, 1'b0);
    step();
    check_run("enter_stage1", 1, 1'b0);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
`ifdef STAGE_SEQ_WATCHDOG_EN
    for (int i = 1; i <= 63; i++) step();
    check_run("wdog_63", 1, 1'b0);
    step();
    check_halted("wdog_64", 1, 2);
`else
    for (int i = 0; i < 100; i++) step();
    check_run("no_wdog", 1, 1'b0);
    check_output("no_wdog.cause", 32'(bus.halt_cause), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
